// File: rtl/counter_field.sv
// counter_field: modulo counter for one clock-datapath field (seconds, minutes, hours).
//
// Counts MIN_COUNT..MAX_COUNT up or down, supports a range-clamped parallel load and
// produces registered one-cycle wrap pulses for cascading plus a registered BCD copy
// of the count for the display driver.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset, loads RESET_VALUE
//   data       in   parallel load value (binary)
//   load       in   load data on the next edge (clamped to range)
//   enable     in   step once on the next edge
//   down       in   direction for enable: 0 = up, 1 = down
//   count      out  current value, binary
//   count_bcd  out  current value as BCD, [7:4] tens, [3:0] units
//   carry      out  one-cycle pulse on up-wrap MAX_COUNT -> MIN_COUNT
//   borrow     out  one-cycle pulse on down-wrap MIN_COUNT -> MAX_COUNT
//   load_error out  one-cycle pulse when the last load was clamped
module counter_field #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned MIN_COUNT   = 0,
  parameter int unsigned MAX_COUNT   = 23,
  parameter int unsigned RESET_VALUE = MIN_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic [7:0]       count_bcd,
  output logic             carry,
  output logic             borrow,
  output logic             load_error
);

  localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);

  // Binary to two-digit BCD; values are at most 99 so both digits fit in 4 bits.
  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [31:0] n;
    logic [31:0] tens;
    logic [31:0] units;
    n     = 32'(v);
    tens  = n / 32'd10;
    units = n % 32'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  localparam logic [7:0] RstBcd = to_bcd(RstVal);

  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       bcd_q;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;
  logic             above_max;
  logic             below_min;

  assign above_max = data > MaxVal;
  // Written as data + 1 <= MIN so the test stays well-formed when MIN_COUNT is 0.
  assign below_min = (32'(data) + 32'd1) <= MIN_COUNT;

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (load) begin
      // Load wins over enable and never produces a wrap pulse.
      if (above_max) begin
        count_d = MaxVal;
        err_d   = 1'b1;
      end else if (below_min) begin
        count_d = MinVal;
        err_d   = 1'b1;
      end else begin
        count_d = data;
      end
    end else if (enable) begin
      if (!down) begin
        if (count_q == MaxVal) begin
          count_d = MinVal;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == MinVal) begin
          count_d  = MaxVal;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= RstVal;
      bcd_q    <= RstBcd;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      // Registered from the next state so it always tracks count in the same cycle.
      bcd_q    <= to_bcd(count_d);
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign count      = count_q;
  assign count_bcd  = bcd_q;
  assign carry      = carry_q;
  assign borrow     = borrow_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_counter_field.sv
module tb_counter_field;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Default instance 0..23
  logic [5:0] d_data;
  logic       d_load, d_en, d_down;
  logic [5:0] d_count;
  logic [7:0] d_bcd;
  logic       d_carry, d_borrow, d_err;

  // 12-hour instance 1..12
  logic [3:0] h_data;
  logic       h_load, h_en, h_down;
  logic [3:0] h_count;
  logic [7:0] h_bcd;
  logic       h_carry, h_borrow, h_err;

  // Chained minutes (0..59) -> hours (0..23)
  logic       ch_en;
  logic [5:0] m_count, r_count;
  logic [7:0] m_bcd, r_bcd;
  logic       m_carry, m_borrow, m_err;
  logic       r_carry, r_borrow, r_err;

  counter_field u_def (
    .clock(clock), .reset(reset), .data(d_data), .load(d_load), .enable(d_en),
    .down(d_down), .count(d_count), .count_bcd(d_bcd), .carry(d_carry),
    .borrow(d_borrow), .load_error(d_err)
  );

  counter_field #(.WIDTH(4), .MIN_COUNT(1), .MAX_COUNT(12)) u_h12 (
    .clock(clock), .reset(reset), .data(h_data), .load(h_load), .enable(h_en),
    .down(h_down), .count(h_count), .count_bcd(h_bcd), .carry(h_carry),
    .borrow(h_borrow), .load_error(h_err)
  );

  counter_field #(.WIDTH(6), .MIN_COUNT(0), .MAX_COUNT(59)) u_min (
    .clock(clock), .reset(reset), .data(6'd0), .load(1'b0), .enable(ch_en),
    .down(1'b0), .count(m_count), .count_bcd(m_bcd), .carry(m_carry),
    .borrow(m_borrow), .load_error(m_err)
  );

  counter_field u_hr (
    .clock(clock), .reset(reset), .data(6'd0), .load(1'b0), .enable(m_carry),
    .down(1'b0), .count(r_count), .count_bcd(r_bcd), .carry(r_carry),
    .borrow(r_borrow), .load_error(r_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: value plus expected pulse flags for each instance.
  int md, mdc, mdb, mde;
  int mh, mhc, mhb, mhe;
  int mm, mmc, mmb, mme;
  int mr, mrc, mrb, mre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Field behaviour from the rules: clamp on load, modular step on enable.
  function automatic void model_step(input int lo, input int hi, input int cur,
                                     input bit ld, input int d, input bit en, input bit dn,
                                     output int nxt, output int c, output int b,
                                     output int e);
    int span;
    span = hi - lo + 1;
    nxt = cur; c = 0; b = 0; e = 0;
    if (ld) begin
      if (d > hi) begin nxt = hi; e = 1; end
      else if (d < lo) begin nxt = lo; e = 1; end
      else nxt = d;
    end else if (en) begin
      if (!dn) begin
        nxt = (cur - lo + 1) % span + lo;
        c = (cur == hi) ? 1 : 0;
      end else begin
        nxt = (cur - lo + span - 1) % span + lo;
        b = (cur == lo) ? 1 : 0;
      end
    end
  endfunction

  task automatic reset_models();
    md = 0; mdc = 0; mdb = 0; mde = 0;
    mh = 1; mhc = 0; mhb = 0; mhe = 0;
    mm = 0; mmc = 0; mmb = 0; mme = 0;
    mr = 0; mrc = 0; mrb = 0; mre = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":d_cnt"}, 32'(d_count), md);
    check({tag, ":d_bcd"}, 32'(d_bcd), bcd(md));
    check({tag, ":d_carry"}, 32'(d_carry), mdc);
    check({tag, ":d_borrow"}, 32'(d_borrow), mdb);
    check({tag, ":d_err"}, 32'(d_err), mde);
    check({tag, ":h_cnt"}, 32'(h_count), mh);
    check({tag, ":h_bcd"}, 32'(h_bcd), bcd(mh));
    check({tag, ":h_carry"}, 32'(h_carry), mhc);
    check({tag, ":h_borrow"}, 32'(h_borrow), mhb);
    check({tag, ":h_err"}, 32'(h_err), mhe);
    check({tag, ":m_cnt"}, 32'(m_count), mm);
    check({tag, ":m_bcd"}, 32'(m_bcd), bcd(mm));
    check({tag, ":m_carry"}, 32'(m_carry), mmc);
    check({tag, ":r_cnt"}, 32'(r_count), mr);
    check({tag, ":r_bcd"}, 32'(r_bcd), bcd(mr));
    check({tag, ":r_carry"}, 32'(r_carry), mrc);
  endtask

  // Advance every model by one edge with the current inputs, clock, then compare.
  task automatic cycle(input string tag);
    int n, c, b, e;
    model_step(0, 23, md, d_load, int'(d_data), d_en, d_down, n, c, b, e);
    md = n; mdc = c; mdb = b; mde = e;
    model_step(1, 12, mh, h_load, int'(h_data), h_en, h_down, n, c, b, e);
    mh = n; mhc = c; mhb = b; mhe = e;
    // Hour field is enabled by the minute carry currently on the wire.
    model_step(0, 23, mr, 1'b0, 0, (mmc != 0), 1'b0, n, c, b, e);
    mr = n; mrc = c; mrb = b; mre = e;
    model_step(0, 59, mm, 1'b0, 0, ch_en, 1'b0, n, c, b, e);
    mm = n; mmc = c; mmb = b; mme = e;
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    reset_models();
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    d_data = '0; d_load = 1'b0; d_en = 1'b0; d_down = 1'b0;
    h_data = '0; h_load = 1'b0; h_en = 1'b0; h_down = 1'b0;
    ch_en = 1'b0;
    apply_reset();

    // Continuous up count through one wrap
    d_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle("up30");
      if (i == 23) check("up30_bcd23", 32'(d_bcd), 32'h23);
      if (i == 24) begin
        check("wrap_bcd00", 32'(d_bcd), 32'h00);
        check("wrap_carry", 32'(d_carry), 32'd1);
      end
    end
    check("up30_end", 32'(d_count), 32'd6);
    d_en = 1'b0;

    // 12-hour down wrap from 1
    h_en = 1'b1; h_down = 1'b1;
    cycle("h12_dn1");
    check("h12_wrap_cnt", 32'(h_count), 32'd12);
    check("h12_wrap_borrow", 32'(h_borrow), 32'd1);
    check("h12_wrap_bcd", 32'(h_bcd), 32'h12);
    cycle("h12_dn2");
    check("h12_11_cnt", 32'(h_count), 32'd11);
    check("h12_11_borrow", 32'(h_borrow), 32'd0);
    check("h12_11_bcd", 32'(h_bcd), 32'h11);
    h_en = 1'b0; h_down = 1'b0;

    // Clamped and in-range loads
    d_load = 1'b1; d_data = 6'd40;
    h_load = 1'b1; h_data = 4'd0;
    cycle("load_clamp");
    check("load40_cnt", 32'(d_count), 32'd23);
    check("load40_err", 32'(d_err), 32'd1);
    check("load0_h12_cnt", 32'(h_count), 32'd1);
    check("load0_h12_err", 32'(h_err), 32'd1);
    h_load = 1'b0;
    d_data = 6'd9;
    cycle("load_ok");
    check("load9_cnt", 32'(d_count), 32'd9);
    check("load9_err", 32'(d_err), 32'd0);

    // Load beats enable at MAX_COUNT
    d_data = 6'd23;
    cycle("load23");
    d_data = 6'd5; d_en = 1'b1;
    cycle("load_vs_en");
    check("load_vs_en_cnt", 32'(d_count), 32'd5);
    check("load_vs_en_carry", 32'(d_carry), 32'd0);
    d_en = 1'b0;

    // Asynchronous reset mid-cycle
    d_data = 6'd17;
    cycle("load17");
    d_load = 1'b0;
    #2;
    reset = 1'b1;
    reset_models();
    #1;
    check("async_rst_cnt", 32'(d_count), 32'd0);
    check("async_rst_bcd", 32'(d_bcd), 32'h00);
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;
    d_en = 1'b1;
    cycle("post_rst");
    check("post_rst_cnt", 32'(d_count), 32'd1);

    // Reset clears a carry pulse in progress
    d_en = 1'b0; d_load = 1'b1; d_data = 6'd23;
    cycle("pre_pulse");
    d_load = 1'b0; d_en = 1'b1;
    cycle("pulse");
    check("pulse_carry", 32'(d_carry), 32'd1);
    d_en = 1'b0;
    #2;
    reset = 1'b1;
    reset_models();
    #1;
    check("pulse_cleared", 32'(d_carry), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      d_load = ($urandom_range(0, 7) == 0);
      d_data = 6'($urandom_range(0, 63));
      d_en   = 1'($urandom_range(0, 1));
      d_down = 1'($urandom_range(0, 1));
      h_load = ($urandom_range(0, 7) == 0);
      h_data = 4'($urandom_range(0, 15));
      h_en   = 1'($urandom_range(0, 1));
      h_down = 1'($urandom_range(0, 1));
      cycle("rand");
    end
    d_load = 1'b0; d_en = 1'b0; h_load = 1'b0; h_en = 1'b0;

    // Minutes -> hours cascade for a full day, with a 20-cycle pause
    apply_reset();
    for (int i = 0; i < 1460; i++) begin
      ch_en = !(i >= 700 && i < 720);
      cycle("chain");
      if (i == 719) begin
        check("pause_min", 32'(m_count), 32'd40);
        check("pause_hr", 32'(r_count), 32'd11);
      end
    end
    check("day_min_wrap", 32'(m_carry), 32'd1);
    ch_en = 1'b0;
    cycle("chain_tail");
    check("day_hr_cnt", 32'(r_count), 32'd0);
    check("day_hr_carry", 32'(r_carry), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_field.md
# counter_field

Parametrised modulo counter for one field of the clock datapath (seconds, minutes, hours). It generalises the fixed hour counter with a configurable range (MIN_COUNT..MAX_COUNT), up/down counting, range-checked load, registered wrap pulses for cascading, and a registered two-digit BCD output for the display driver. Instances chain by connecting one field's `carry`/`borrow` to the next field's `enable`.

## Interface
- `WIDTH`, 6: bit width of binary `data` and `count`; must satisfy 2^WIDTH > MAX_COUNT.
- `MIN_COUNT`, 0: lowest count value; 0 for 24 h / minutes / seconds, 1 for 12 h.
- `MAX_COUNT`, 23: highest count value; MIN_COUNT < MAX_COUNT <= 99.
- `RESET_VALUE`, MIN_COUNT: value loaded by reset; must lie in MIN_COUNT..MAX_COUNT.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  WIDTH  parallel load value (binary).
- `load`  in  1  load `data` on the next rising edge.
- `enable`  in  1  count one step on the next rising edge.
- `down`  in  1  direction: 0 = increment, 1 = decrement; sampled with `enable`.
- `count`  out  WIDTH  current value, binary.
- `count_bcd`  out  8  current value as BCD, [7:4] tens, [3:0] units.
- `carry`  out  1  one-cycle pulse: up-count wrapped MAX_COUNT -> MIN_COUNT.
- `borrow`  out  1  one-cycle pulse: down-count wrapped MIN_COUNT -> MAX_COUNT.
- `load_error`  out  1  one-cycle pulse: last load was out of range and was clamped.

## Operation
- Reset asserted: `count` = RESET_VALUE, `count_bcd` = BCD(RESET_VALUE), `carry` = `borrow` = `load_error` = 0, immediately and held while `reset` = 1.
- Priority per edge: reset > load > enable > hold.
- Load: `data` in MIN_COUNT..MAX_COUNT -> `count` = `data`. `data` > MAX_COUNT -> `count` = MAX_COUNT, `load_error` = 1. `data` < MIN_COUNT -> `count` = MIN_COUNT, `load_error` = 1. A load never produces `carry` or `borrow`.
- Enable, `down` = 0: `count` = MAX_COUNT ? MIN_COUNT with `carry` = 1 : `count` + 1.
- Enable, `down` = 1: `count` = MIN_COUNT ? MAX_COUNT with `borrow` = 1 : `count` - 1.
- Neither: hold `count`. `carry`, `borrow` and `load_error` return to 0 on every edge where their condition is not met.
- `count` never leaves MIN_COUNT..MAX_COUNT. Arithmetic is WIDTH bits with no overflow path.
- `count_bcd` is registered from the next-state value, so it always matches `count` on the same cycle. Tens digit = value / 10, units = value mod 10, with both in 0..9.

## Timing
- Latency: 1 cycle from the sampled `load`/`enable` edge to the new `count`/`count_bcd`.
- `carry`/`borrow`/`load_error` are registered. Each is high for exactly the one cycle in which `count` shows the wrapped or clamped value.
- Continuous `enable` = 1, up: `carry` pulses once every (MAX_COUNT - MIN_COUNT + 1) cycles.
- Cascading: a downstream field with `enable` = upstream `carry` advances on the edge after the wrap. This one-cycle skew is accepted.
- `load` and `enable` together: load wins, with no step and no wrap pulse, even if `count` = MAX_COUNT.
- `down` toggling while `enable` = 1: the direction applies on the edge where it is sampled, with no dead cycle.
- Reset mid-count or mid-pulse: a pulse in progress is cleared immediately. The first enabled edge after deassertion steps from RESET_VALUE.

## Test plan
- Defaults (0..23). Reset, then `enable` = 1 for 30 cycles -> `count` 0,1,…,23,0,…,6. `carry` is high only in the cycle `count` = 0 after 23. `count_bcd` = 8'h23 at 23 and 8'h00 at wrap.
- MIN_COUNT = 1, MAX_COUNT = 12, `down` = 1 from `count` = 1 -> next 12 with `borrow` = 1, then 11 with `borrow` = 0. `count_bcd` = 8'h12, then 8'h11.
- Load `data` = 40 (defaults) -> `count` = 23, `load_error` = 1 for one cycle. Load `data` = 9 -> `count` = 9, `load_error` = 0. With MIN_COUNT = 1, load 0 -> `count` = 1, `load_error` = 1.
- `count` = 23, `load` = 1 with `data` = 5 and `enable` = 1 on the same edge -> `count` = 5, `carry` = 0.
- Assert `reset` asynchronously mid-cycle while `count` = 17 -> `count` = 0 and `count_bcd` = 8'h00 before the next edge. Deassert, one enable -> 1.
- Two instances chained (0..59, then 0..23) with `enable` = 1 for 60×24 cycles -> the hour field steps once per minute wrap and returns to 0 with `carry` after the final minute wrap. `enable` low for 20 cycles mid-run -> both fields hold.
